// File: rtl/z80_mmu_pkg.sv
// Shared definitions for the paged Z80 MMU: entry flag positions, FSM
// encoding and the page-table window base address.
package z80_mmu_pkg;

  localparam int VALID_BIT = 0;
  localparam int WP_BIT    = 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // The window holds two bytes per entry and sits at the top of the 64K map.
  function automatic logic [15:0] win_base(input int page_bits);
    logic [31:0] b;
    b = 32'h0001_0000 - (32'd2 << (16 - page_bits));
    return b[15:0];
  endfunction

endpackage

// File: rtl/z80_mmu_page_table.sv
// Page-table storage: identity map at reset, low-byte staging register and
// atomic 16-bit commit, plus a window read port and a translation read port.
module z80_mmu_page_table
  import z80_mmu_pkg::*;
#(
  parameter int PA        = 12,
  parameter int PAGE_BITS = 8,
  parameter int FLAGS     = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    stage_we_i,
  input  logic                    commit_we_i,
  input  logic [7:0]              din_i,
  input  logic [15-PAGE_BITS:0]   win_idx_i,
  input  logic [15-PAGE_BITS:0]   page_idx_i,
  output logic [FLAGS+PA-1:0]     win_entry_o,
  output logic [FLAGS+PA-1:0]     page_entry_o
);

  localparam int SIZE = 1 << (16 - PAGE_BITS);
  localparam int EW   = FLAGS + PA;

  logic [EW-1:0] entries_q [SIZE];
  logic [7:0]    staging_q;
  logic [15:0]   commit_word;

  // Bits above the entry width are dropped on commit.
  assign commit_word = {din_i, staging_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      staging_q <= '0;
      for (int i = 0; i < SIZE; i++) begin
        entries_q[i]               <= '0;
        entries_q[i][FLAGS +: PA]  <= PA'(i);
        entries_q[i][VALID_BIT]    <= 1'b1;
      end
    end else begin
      if (stage_we_i)  staging_q <= din_i;
      if (commit_we_i) entries_q[win_idx_i] <= commit_word[EW-1:0];
    end
  end

  assign win_entry_o  = entries_q[win_idx_i];
  assign page_entry_o = entries_q[page_idx_i];

endmodule

// File: rtl/z80_paged_mmu.sv
// Clocked paged MMU between the Z80 bus and RAM. Define Z80_MMU_WP_EN to make
// the per-entry WP flag block writes (fault instead of a RAM write).
module z80_paged_mmu
  import z80_mmu_pkg::*;
#(
  parameter int PA        = 12,
  parameter int PAGE_BITS = 8,
  parameter int FLAGS     = 4
) (
  input  logic                    CLK,
  input  logic                    nRESET,
  input  logic                    nMREQ,
  input  logic                    nRD,
  input  logic                    nWR,
  input  logic                    nRFSH,
  input  logic [15:0]             virtual_addr,
  input  logic [7:0]              cpu_din,
  output logic [7:0]              cpu_dout,
  output logic                    cpu_doe,
  output logic [PA+PAGE_BITS-1:0] physical_addr,
  output logic                    ram_nCS,
  output logic                    ram_nOE,
  output logic                    ram_nWE,
  output logic [FLAGS-3:0]        page_flags,
  output logic                    fault,
  output logic [15:0]             fault_vaddr
);

  localparam int          IDX_W    = 16 - PAGE_BITS;
  localparam int          EW       = FLAGS + PA;
  localparam logic [15:0] WIN_BASE = win_base(PAGE_BITS);
`ifdef Z80_MMU_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  state_e                  state_q, state_d;
  logic [15:0]             addr_q;
  logic                    done_q, done_d;
  logic [7:0]              cpu_dout_q, cpu_dout_d;
  logic                    cpu_doe_q, cpu_doe_d;
  logic [PA+PAGE_BITS-1:0] phys_q, phys_d;
  logic [FLAGS-3:0]        flags_q, flags_d;
  logic                    ncs_q, ncs_d, noe_q, noe_d, nwe_q, nwe_d;
  logic                    fault_q, fault_d;
  logic [15:0]             fva_q, fva_d;
  logic                    stage_we, commit_we;
  logic [EW-1:0]           win_entry, page_entry;
  logic [15:0]             win_word;
  logic                    in_win, fault_cond;

  z80_mmu_page_table #(.PA(PA), .PAGE_BITS(PAGE_BITS), .FLAGS(FLAGS)) u_tbl (
    .clk_i        (CLK),
    .rst_ni       (nRESET),
    .stage_we_i   (stage_we),
    .commit_we_i  (commit_we),
    .din_i        (cpu_din),
    .win_idx_i    (addr_q[IDX_W:1]),
    .page_idx_i   (addr_q[15:PAGE_BITS]),
    .win_entry_o  (win_entry),
    .page_entry_o (page_entry)
  );

  assign win_word   = 16'(win_entry);
  assign in_win     = (addr_q >= WIN_BASE);
  assign fault_cond = !page_entry[VALID_BIT] || (WP_EN && !nWR && page_entry[WP_BIT]);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && state_d == ST_ACCESS) addr_q <= virtual_addr;
    end
  end

  // Refresh cycles also pull nMREQ low; they must not start an access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!nMREQ && nRFSH) state_d = ST_ACCESS;
      ST_ACCESS: if (nMREQ)           state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_dout_d = '0;
    cpu_doe_d  = 1'b0;
    phys_d     = '0;
    flags_d    = '0;
    ncs_d      = 1'b1;
    noe_d      = 1'b1;
    nwe_d      = 1'b1;
    fault_d    = 1'b0;
    fva_d      = fva_q;
    done_d     = done_q;
    stage_we   = 1'b0;
    commit_we  = 1'b0;
    if (state_q == ST_IDLE) begin
      done_d = 1'b0;
    end else if (!nMREQ) begin
      if (in_win) begin
        cpu_doe_d = !nRD;
        if (!nRD) cpu_dout_d = addr_q[0] ? win_word[15:8] : win_word[7:0];
        if (!nWR && !done_q) begin
          done_d    = 1'b1;
          stage_we  = !addr_q[0];
          commit_we = addr_q[0];
        end
      end else if (fault_cond) begin
        if (!done_q) begin
          done_d  = 1'b1;
          fault_d = 1'b1;
          fva_d   = addr_q;
        end
      end else begin
        phys_d  = {page_entry[FLAGS +: PA], addr_q[PAGE_BITS-1:0]};
        flags_d = page_entry[FLAGS-1:2];
        ncs_d   = 1'b0;
        noe_d   = nRD;
        nwe_d   = nWR;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      done_q     <= 1'b0;
      cpu_dout_q <= '0;
      cpu_doe_q  <= 1'b0;
      phys_q     <= '0;
      flags_q    <= '0;
      ncs_q      <= 1'b1;
      noe_q      <= 1'b1;
      nwe_q      <= 1'b1;
      fault_q    <= 1'b0;
      fva_q      <= '0;
    end else begin
      done_q     <= done_d;
      cpu_dout_q <= cpu_dout_d;
      cpu_doe_q  <= cpu_doe_d;
      phys_q     <= phys_d;
      flags_q    <= flags_d;
      ncs_q      <= ncs_d;
      noe_q      <= noe_d;
      nwe_q      <= nwe_d;
      fault_q    <= fault_d;
      fva_q      <= fva_d;
    end
  end

  assign cpu_dout      = cpu_dout_q;
  assign cpu_doe       = cpu_doe_q;
  assign physical_addr = phys_q;
  assign page_flags    = flags_q;
  assign ram_nCS       = ncs_q;
  assign ram_nOE       = noe_q;
  assign ram_nWE       = nwe_q;
  assign fault         = fault_q;
  assign fault_vaddr   = fva_q;

endmodule

// File: tb/tb_z80_paged_mmu.sv
// Scoreboard bench for z80_paged_mmu: a page-table model predicts each bus
// event, a monitor pops and compares whenever the DUT shows RAM/fault/window activity.
module tb_z80_paged_mmu;

  logic        CLK = 1'b0, nRESET = 1'b0;
  logic        nMREQ = 1'b1, nRD = 1'b1, nWR = 1'b1, nRFSH = 1'b1;
  logic [15:0] virtual_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_doe;
  logic [19:0] physical_addr;
  logic        ram_nCS, ram_nOE, ram_nWE;
  logic [1:0]  page_flags;
  logic        fault;
  logic [15:0] fault_vaddr;

`ifdef Z80_MMU_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  z80_paged_mmu dut (
    .CLK(CLK), .nRESET(nRESET), .nMREQ(nMREQ), .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH),
    .virtual_addr(virtual_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_doe(cpu_doe),
    .physical_addr(physical_addr), .ram_nCS(ram_nCS), .ram_nOE(ram_nOE), .ram_nWE(ram_nWE),
    .page_flags(page_flags), .fault(fault), .fault_vaddr(fault_vaddr)
  );

  always #5 CLK = ~CLK;

  // kind: 0 = RAM access, 1 = fault, 2 = window read
  typedef struct {
    int          kind;
    logic [19:0] pa;
    logic        noe, nwe;
    logic [1:0]  flg;
    logic [7:0]  dout;
    logic [15:0] fva;
  } exp_t;

  exp_t        q[$];
  logic [15:0] tbl [256];
  logic [7:0]  stg;
  int          total = 0, passed = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) tbl[i] = (16'(i) << 4) | 16'h0001;
    stg = '0;
  endtask

  task automatic model_access(input logic [15:0] a, input bit wr, input logic [7:0] d);
    exp_t e;
    logic [15:0] ent;
    e.kind = 0; e.pa = '0; e.noe = 1'b1; e.nwe = 1'b1; e.flg = '0; e.dout = '0; e.fva = '0;
    if (a >= 16'hFE00) begin
      ent = tbl[a[8:1]];
      if (wr) begin
        if (!a[0]) stg = d;
        else       tbl[a[8:1]] = {d, stg};
      end else begin
        e.kind = 2;
        e.dout = a[0] ? ent[15:8] : ent[7:0];
        q.push_back(e);
      end
    end else begin
      ent = tbl[a[15:8]];
      if (!ent[0] || (WP_EN && wr && ent[1])) begin
        e.kind = 1;
        e.fva  = a;
      end else begin
        e.kind = 0;
        e.pa   = {ent[15:4], a[7:0]};
        e.noe  = wr;
        e.nwe  = !wr;
        e.flg  = ent[3:2];
      end
      q.push_back(e);
    end
  endtask

  // nMREQ first, the read/write strobe one cycle later, then two cycles held.
  task automatic bus(input logic [15:0] a, input bit wr, input logic [7:0] d);
    @(negedge CLK);
    virtual_addr = a; cpu_din = d; nMREQ = 1'b0;
    model_access(a, wr, d);
    @(negedge CLK);
    if (wr) nWR = 1'b0; else nRD = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nMREQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
  endtask

  task automatic rfsh(input logic [15:0] a);
    @(negedge CLK);
    virtual_addr = a; nMREQ = 1'b0; nRFSH = 1'b0;
    repeat (2) @(negedge CLK);
    @(negedge CLK);
    nMREQ = 1'b1; nRFSH = 1'b1;
  endtask

  task automatic wentry(input logic [7:0] idx, input logic [15:0] w);
    bus(16'hFE00 + {7'd0, idx, 1'b0}, 1'b1, w[7:0]);
    bus(16'hFE01 + {7'd0, idx, 1'b0}, 1'b1, w[15:8]);
  endtask

  // Monitor: one comparison per new burst of bus activity.
  initial begin
    bit   prev, act, pchk;
    int   k;
    exp_t e;
    prev = 1'b0; pchk = 1'b0;
    forever begin
      @(negedge CLK);
      if (!nRESET) begin
        prev = 1'b0; pchk = 1'b0;
      end else begin
        if (pchk) begin
          chk(fault == 1'b0, "fault pulse width", fault, 0);
          pchk = 1'b0;
        end
        act = !ram_nCS || fault || cpu_doe;
        if (act && !prev) begin
          k = fault ? 1 : (cpu_doe ? 2 : 0);
          if (fault) pchk = 1'b1;
          chk(q.size() != 0, "event expected", q.size(), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk(k == e.kind, "event kind", k, e.kind);
            if (k == e.kind) begin
              case (k)
                0: begin
                  chk(physical_addr == e.pa, "physical_addr", physical_addr, e.pa);
                  chk({ram_nOE, ram_nWE, page_flags} == {e.noe, e.nwe, e.flg},
                      "nOE/nWE/flags", {ram_nOE, ram_nWE, page_flags}, {e.noe, e.nwe, e.flg});
                end
                1: chk(fault_vaddr == e.fva && ram_nCS && ram_nWE, "fault_vaddr/nCS",
                       {ram_nCS, fault_vaddr}, {1'b1, e.fva});
                default: chk(cpu_dout == e.dout, "window cpu_dout", cpu_dout, e.dout);
              endcase
            end
          end
        end
        prev = act;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

  initial begin
    int          r;
    logic [7:0]  idx, lo, hi;
    model_reset();
    repeat (3) @(negedge CLK);
    chk(physical_addr === '0, "reset physical_addr", physical_addr, 0);
    chk(ram_nCS === 1'b1, "reset ram_nCS", ram_nCS, 1);
    chk(ram_nOE === 1'b1, "reset ram_nOE", ram_nOE, 1);
    chk(ram_nWE === 1'b1, "reset ram_nWE", ram_nWE, 1);
    chk(fault === 1'b0, "reset fault", fault, 0);
    chk(fault_vaddr === '0, "reset fault_vaddr", fault_vaddr, 0);
    chk(cpu_doe === 1'b0, "reset cpu_doe", cpu_doe, 0);
    chk(cpu_dout === '0, "reset cpu_dout", cpu_dout, 0);
    nRESET = 1'b1;

    bus(16'hFE00, 1'b0, 8'h00);
    bus(16'hFE01, 1'b0, 8'h00);
    bus(16'hFE58, 1'b1, 8'h01);
    bus(16'hFE59, 1'b1, 8'h8E);
    bus(16'h2C34, 1'b0, 8'h00);
    bus(16'hFE58, 1'b1, 8'h00);
    bus(16'h2C34, 1'b1, 8'h5A);
    wentry(8'h10, 16'h0100);
    bus(16'h1000, 1'b0, 8'h00);
    wentry(8'h20, 16'h0203);
    bus(16'h2000, 1'b1, 8'hA5);
    bus(16'h2000, 1'b0, 8'h00);
    bus(16'hFDFF, 1'b0, 8'h00);
    bus(16'hFFFF, 1'b0, 8'h00);
    rfsh(16'h3000);
    rfsh(16'hFE10);

    // Reset lands while a high-byte window write is in flight.
    bus(16'hFE20, 1'b1, 8'h55);
    @(negedge CLK);
    virtual_addr = 16'hFE21; cpu_din = 8'h00; nMREQ = 1'b0;
    @(negedge CLK);
    nWR = 1'b0; nRESET = 1'b0;
    model_reset();
    @(negedge CLK);
    chk(ram_nCS && ram_nOE && ram_nWE && !fault && !cpu_doe, "strobes in reset",
        {ram_nCS, ram_nOE, ram_nWE, fault, cpu_doe}, 5'b11100);
    nMREQ = 1'b1; nWR = 1'b1;
    @(negedge CLK);
    nRESET = 1'b1;
    bus(16'hFE20, 1'b0, 8'h00);
    bus(16'hFE21, 1'b0, 8'h00);
    bus(16'h1000, 1'b0, 8'h00);
    bus(16'hFE21, 1'b1, 8'h01);
    bus(16'h1000, 1'b0, 8'h00);

    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 99);
      if (r < 15) begin
        idx = 8'($urandom); lo = 8'($urandom); hi = 8'($urandom);
        lo[0] = ($urandom_range(0, 3) != 0);
        bus(16'hFE00 + {7'd0, idx, 1'b0}, 1'b1, lo);
        if ($urandom_range(0, 4) != 0) bus(16'hFE01 + {7'd0, idx, 1'b0}, 1'b1, hi);
      end else if (r < 30) begin
        bus(16'hFE00 | 16'($urandom_range(0, 511)), 1'b0, 8'h00);
      end else if (r < 35) begin
        rfsh(16'($urandom));
      end else begin
        bus(16'($urandom_range(0, 16'hFDFF)), 1'($urandom_range(0, 1)), 8'($urandom));
      end
    end

    repeat (4) @(negedge CLK);
    chk(q.size() == 0, "pending expectations", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/z80_paged_mmu.md
# z80_paged_mmu

Clocked, parametrised successor to the combinational Z80 MMU. It sits between the Z80 bus and external RAM and translates the 16-bit CPU address into a PA+PAGE_BITS physical address through a register page table. The table is loaded through a memory-mapped window, and each entry is committed atomically. Per-page VALID and write-protect flags raise a fault instead of accessing RAM.

## Interface
- PA, 12: physical page-number bits.
- PAGE_BITS, 8: offset bits; SIZE = 2**(16-PAGE_BITS) entries.
- FLAGS, 4: flag bits per entry; FLAGS+PA ≤ 16.
- CLK  in  1  Z80 clock; all state on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- nMREQ, nRD, nWR, nRFSH  in  1  Z80 bus strobes, active-low.
- virtual_addr  in  16  CPU address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  window read data.
- cpu_doe  out  1  high when cpu_dout drives the CPU bus.
- physical_addr  out  PA+PAGE_BITS  translated address.
- ram_nCS, ram_nOE, ram_nWE  out  1  RAM strobes, active-low.
- page_flags  out  FLAGS-2  user flag bits of the current entry.
- fault  out  1  one-cycle pulse on a faulting access.
- fault_vaddr  out  16  virtual address of the last fault.

## Operation
- Entry layout: bit 0 = VALID; bit 1 = WP; bits FLAGS-1:2 = user bits; bits FLAGS+PA-1:FLAGS = physical page.
- Window: virtual addresses ≥ 0x10000 − 2·SIZE (0xFE00–0xFFFF at default).
  - Entry index = virtual_addr[log2(SIZE):1].
  - virtual_addr[0]=0 selects the low byte; virtual_addr[0]=1 selects the high byte.
  - Window accesses never touch RAM.
- Window writes:
  - A low-byte write loads an 8-bit staging register only.
  - A high-byte write commits {cpu_din, staging} to the entry in one edge.
  - Bits beyond FLAGS+PA are discarded.
- Window reads: cpu_dout = selected live entry byte, zero-extended; cpu_doe = 1 while nRD is low in ACCESS.
- FSM states:
  - IDLE: on a sampled nMREQ=0 with nRFSH=1, latch virtual_addr and go to ACCESS. Refresh cycles are ignored.
  - ACCESS: drive outputs from the latched address. When nMREQ=1 is sampled, return to IDLE.
- Once-per-cycle actions: the window commit and the fault pulse each occur at most once per ACCESS, guarded by a done flag set on first action.
- RAM access in ACCESS, non-window, VALID=1:
  - physical_addr = {entry page, offset}; ram_nCS = 0.
  - ram_nOE = nRD; ram_nWE = nWR.
- Fault:
  - Condition: VALID=0, or a write to a WP page (WP only with the macro).
  - ram_nCS stays 1; fault pulses on the first cycle the condition holds; fault_vaddr is latched.
- Reset values:
  - FSM = IDLE; entry i = {i[PA-1:0], user 0, WP 0, VALID 1} (identity map).
  - staging = 0; physical_addr = 0; cpu_dout = 0; cpu_doe = 0.
  - ram_nCS = ram_nOE = ram_nWE = 1; fault = 0; fault_vaddr = 0.

## Timing
- Translation latency: nMREQ sampled low at edge N → physical_addr valid and ram_nCS = 0 after edge N+1.
- Z80 nWR arrives one or more cycles after nMREQ. ram_nWE follows each sampled nWR with one-cycle latency.
- Window commit happens on the first edge in ACCESS where nWR is sampled low.
- nMREQ sampled high at edge M: all strobes and cpu_doe return to 1/0 after edge M.
- Asynchronous reset mid-ACCESS forces reset values immediately; a pending commit is lost and the staging register is cleared.
- A high-byte write whose entry is the one currently mapping the access takes effect from the next ACCESS.

## Configuration
- Z80_MMU_WP_EN defined: a write to a WP=1 page suppresses ram_nWE (and ram_nCS) and raises fault. Reads are unaffected.
- Z80_MMU_WP_EN undefined: bit 1 is stored and readable but ignored for access control.

## Structure
- Package z80_mmu_pkg holds:
  - flag bit indices (VALID_BIT, WP_BIT);
  - FSM state encodings;
  - window-base computation function from PAGE_BITS.
- Sub-module z80_mmu_page_table: entry storage, staging register, atomic commit, reset identity init and read port. The top level holds the FSM, strobes and fault logic.

## Test plan
- Reset → read window bytes 0xFE00/0xFE01 → 0x01 and 0x00 (entry 0 = page 0, VALID); RAM strobes stay 1.
- Write 0xFE58 = 0x01, then 0xFE59 = 0x8E → access 0x2C34 → physical_addr = 0x8E034 (default parameters), ram_nCS = 0.
- Write only the low byte 0xFE58 = 0x00 → entry 0x2C is unchanged; 0x2C34 still maps to 0x8E034.
- Clear VALID of page 0x10 → read 0x1000 → ram_nCS stays 1, fault pulses 1 cycle, fault_vaddr = 0x1000.
- With Z80_MMU_WP_EN, set WP on page 0x20 → write 0x2000 → ram_nWE stays 1, fault pulses. A read of 0x2000 succeeds.
- Assert nRESET during a window high-byte write → the entry stays at its identity value; refresh cycles (nRFSH = 0) produce no strobes.
